// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32I front-end pipeline registers.
package riscv_pipe_pkg;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_e;

  localparam int          PC_W_DEF      = 32;
  localparam int          INSTR_W_DEF   = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } if_id_t;
endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register plus valid bit; kill beats load, load beats drop.
module pipe_skid_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         kill_i,
  input  logic         load_i,
  input  logic         drop_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o
);
  logic [W-1:0] data_q;
  logic         vld_q;

  // Data is left untouched on kill/drop so the PC keeps its last value.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (kill_i) begin
      vld_q  <= 1'b0;
    end else if (load_i) begin
      data_q <= d_i;
      vld_q  <= 1'b1;
    end else if (drop_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID stage: PC+instruction hand-off with stall, flush and optional skid entry.
module if_id_pipe_stage
  import riscv_pipe_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter bit                 SKID_EN   = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);
  localparam int W = PC_W + INSTR_W;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } payload_t;

  pipe_state_e state_q, state_d;
  payload_t    in_pl, main_d, main_q, skid_q;
  logic        main_vld, skid_vld, in_ready_q;
  logic        acc, con, main_ld;

  assign in_pl = '{pc: in_pc, instr: in_instr};
  assign acc   = in_valid && in_ready;
  assign con   = out_valid && out_ready;

  // Skid entry only ever holds data in FULL, so its valid bit selects the source.
  assign main_d  = skid_vld ? skid_q : in_pl;
  assign main_ld = (acc && (!main_vld || con)) || (skid_vld && con);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (acc) state_d = BUSY;
        BUSY: begin
          if (acc && !con)      state_d = FULL;
          else if (!acc && con) state_d = EMPTY;
        end
        FULL:    if (con) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  pipe_skid_entry #(.W(W)) u_main (
    .clk    (clk),
    .rst_ni (rst),
    .kill_i (flush),
    .load_i (main_ld),
    .drop_i (con),
    .d_i    (main_d),
    .q_o    (main_q),
    .vld_o  (main_vld)
  );

  if (SKID_EN) begin : g_skid
    pipe_skid_entry #(.W(W)) u_skid (
      .clk    (clk),
      .rst_ni (rst),
      .kill_i (flush),
      .load_i ((state_q == BUSY) && acc && !con),
      .drop_i ((state_q == FULL) && con),
      .d_i    (in_pl),
      .q_o    (skid_q),
      .vld_o  (skid_vld)
    );
  end else begin : g_noskid
    assign skid_q   = '0;
    assign skid_vld = 1'b0;
  end

  // Gating with rst keeps in_ready low through reset and high right after release.
  assign in_ready  = rst && (SKID_EN ? in_ready_q : (!out_valid || out_ready));
  assign out_valid = main_vld;
  assign out_pc    = main_q.pc;
  assign out_instr = main_vld ? main_q.instr : NOP_INSTR;
endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed bench: skid variant (a_*) and no-skid variant (b_*) of the IF/ID stage.
module tb_if_id_pipe_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_iv = 0, a_ir, a_ov, a_or = 0;
  logic [31:0] a_ipc = 0, a_iin = 0, a_opc, a_oin;
  logic        b_flush = 0, b_iv = 0, b_ir, b_ov, b_or = 0;
  logic [31:0] b_ipc = 0, b_iin = 0, b_opc, b_oin;

  int n_cmp = 0;
  int n_bad = 0;

  if_id_pipe_stage #(.SKID_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_pc(a_ipc), .in_instr(a_iin), .out_valid(a_ov), .out_ready(a_or),
    .out_pc(a_opc), .out_instr(a_oin));

  if_id_pipe_stage #(.SKID_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_pc(b_ipc), .in_instr(b_iin), .out_valid(b_ov), .out_ready(b_or),
    .out_pc(b_opc), .out_instr(b_oin));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hA5A5_0000 | pc;
  endfunction

  task automatic chk_a(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic rdy);
    chk({tag, ".ov"}, {31'd0, a_ov}, {31'd0, v});
    chk({tag, ".pc"}, a_opc, pc);
    chk({tag, ".in"}, a_oin, instr);
    chk({tag, ".ir"}, {31'd0, a_ir}, {31'd0, rdy});
  endtask

  initial begin
    // Reset held 3 cycles with fetch presenting a pair
    a_iv = 1; a_ipc = 32'h99; a_iin = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    chk_a("rst", 0, 32'h0, 32'h13, 0);
    chk("rst_b.ov", {31'd0, b_ov}, 32'd0);
    chk("rst_b.ir", {31'd0, b_ir}, 32'd0);
    a_iv = 0;
    rst = 1;
    tick();
    chk_a("post_rst", 0, 32'h0, 32'h13, 1);

    // Streaming, no bubbles
    a_or = 1; a_iv = 1; a_ipc = 32'h00; a_iin = 32'h0050_0093;
    tick(); chk_a("s0", 1, 32'h00, 32'h0050_0093, 1);
    a_ipc = 32'h04; a_iin = 32'h0010_0113;
    tick(); chk_a("s1", 1, 32'h04, 32'h0010_0113, 1);
    a_ipc = 32'h08; a_iin = 32'h0020_81B3;
    tick(); chk_a("s2", 1, 32'h08, 32'h0020_81B3, 1);
    a_iv = 0;
    tick(); chk_a("s_drain", 0, 32'h08, 32'h13, 1);

    // Stall with skid
    a_or = 0; a_iv = 1; a_ipc = 32'h10; a_iin = ins(32'h10);
    tick(); chk_a("st0", 1, 32'h10, ins(32'h10), 1);
    a_ipc = 32'h14; a_iin = ins(32'h14);
    tick(); chk_a("st1", 1, 32'h10, ins(32'h10), 0);
    a_ipc = 32'h18; a_iin = ins(32'h18);
    tick(); chk_a("st2", 1, 32'h10, ins(32'h10), 0);
    tick(); chk_a("st3", 1, 32'h10, ins(32'h10), 0);
    a_or = 1;
    tick(); chk_a("st_rel0", 1, 32'h14, ins(32'h14), 1);
    tick(); chk_a("st_rel1", 1, 32'h18, ins(32'h18), 1);
    a_iv = 0;
    tick(); chk_a("st_drain", 0, 32'h18, 32'h13, 1);

    // Flush in FULL with a pair presented
    a_or = 0; a_iv = 1; a_ipc = 32'h30; a_iin = ins(32'h30);
    tick();
    a_ipc = 32'h34; a_iin = ins(32'h34);
    tick(); chk_a("fl_full", 1, 32'h30, ins(32'h30), 0);
    a_flush = 1; a_ipc = 32'h20; a_iin = ins(32'h20);
    tick(); chk_a("fl0", 0, 32'h30, 32'h13, 1);
    a_flush = 0; a_iv = 0; a_or = 1;
    tick(); chk_a("fl1", 0, 32'h30, 32'h13, 1);
    tick(); chk_a("fl2", 0, 32'h30, 32'h13, 1);

    // Async reset while FULL
    a_or = 0; a_iv = 1; a_ipc = 32'h50; a_iin = ins(32'h50);
    tick();
    a_ipc = 32'h54; a_iin = ins(32'h54);
    tick(); chk_a("ar_full", 1, 32'h50, ins(32'h50), 0);
    #2 rst = 0;
    #1 chk("ar_async.ov", {31'd0, a_ov}, 32'd0);
    chk("ar_async.in", a_oin, 32'h13);
    chk("ar_async.ir", {31'd0, a_ir}, 32'd0);
    a_iv = 0;
    tick();
    rst = 1; a_or = 1; a_iv = 1; a_ipc = 32'h40; a_iin = ins(32'h40);
    tick(); chk_a("ar_40", 1, 32'h40, ins(32'h40), 1);
    a_iv = 0;
    tick(); chk_a("ar_alone", 0, 32'h40, 32'h13, 1);
    tick(); chk_a("ar_idle", 0, 32'h40, 32'h13, 1);

    // No-skid variant: combinational in_ready, order preserved
    b_or = 0; b_iv = 1; b_ipc = 32'h10; b_iin = ins(32'h10);
    #1 chk("b_empty.ir", {31'd0, b_ir}, 32'd1);
    tick();
    chk("b0.ov", {31'd0, b_ov}, 32'd1);
    chk("b0.pc", b_opc, 32'h10);
    chk("b0.ir", {31'd0, b_ir}, 32'd0);
    b_ipc = 32'h14; b_iin = ins(32'h14);
    b_or = 1; #1 chk("b_comb1.ir", {31'd0, b_ir}, 32'd1);
    b_or = 0; #1 chk("b_comb0.ir", {31'd0, b_ir}, 32'd0);
    tick();
    chk("b_st1.pc", b_opc, 32'h10);
    chk("b_st1.in", b_oin, ins(32'h10));
    tick();
    chk("b_st2.pc", b_opc, 32'h10);
    b_or = 1;
    tick();
    chk("b_r0.pc", b_opc, 32'h14);
    chk("b_r0.in", b_oin, ins(32'h14));
    b_ipc = 32'h18; b_iin = ins(32'h18);
    tick();
    chk("b_r1.pc", b_opc, 32'h18);
    chk("b_r1.ov", {31'd0, b_ov}, 32'd1);
    b_iv = 0;
    tick();
    chk("b_drain.ov", {31'd0, b_ov}, 32'd0);
    chk("b_drain.in", b_oin, 32'h13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_id_pipe_stage.md
Name: if_id_pipe_stage

Overview:
- Parametrised successor to the fixed IF/ID register.
- Carries PC and instruction from fetch to decode with a valid/ready handshake, decode-side stall, and branch flush.
- An optional skid entry registers in_ready, so fetch never sees a combinational path from decode back-pressure.
- Sits between the fetch unit and the decoder of the RV32I pipeline.

Parameters:
PC_W, 32, width of the PC field
INSTR_W, 32, width of the instruction field
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with in_ready = !out_valid || out_ready
NOP_INSTR, 32'h0000_0013, value driven on out_instr when the stage is empty or flushed (ADDI x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  kill all held entries (taken branch or jump)
in_valid  in  1  fetch presents a PC/instruction pair
in_ready  out  1  stage accepts the pair this cycle
in_pc  in  PC_W  fetch PC
in_instr  in  INSTR_W  fetched instruction
out_valid  out  1  decode-side entry is valid
out_ready  in  1  decoder consumes the entry this cycle (0 = stall)
out_pc  out  PC_W  held PC
out_instr  out  INSTR_W  held instruction, or NOP_INSTR when out_valid = 0

Behaviour:
- Reset (rst = 0, async assert, sync deassert at the board level):
  - out_valid = 0, out_pc = 0, out_instr = NOP_INSTR.
  - Skid entry cleared.
  - in_ready = 1 while rst = 1 after release, and 0 while rst = 0.
- Transfer rules: in-accept = in_valid && in_ready; out-consume = out_valid && out_ready. Latency is 1 cycle from accept to out_valid.
- SKID_EN = 1, state machine:
  - EMPTY: out_valid = 0, in_ready = 1. Accept -> BUSY, loading the main register.
  - BUSY: out_valid = 1, in_ready = 1.
    - Accept and consume: reload main, stay BUSY.
    - Consume only -> EMPTY.
    - Accept only (stall) -> FULL, writing the pair into the skid register.
    - Neither: hold.
  - FULL: out_valid = 1, in_ready = 0. Consume -> BUSY, moving skid into main. in_valid is ignored.
  - in_ready is a flop output: asserted exactly when the next state is not FULL.
- SKID_EN = 0:
  - States are EMPTY and BUSY only.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept with concurrent consume gives back-to-back throughput.
- Flush:
  - Next edge forces EMPTY: out_valid = 0 and the skid entry is invalidated.
  - Flush has priority over accept in the same cycle; the fetched pair is dropped.
  - out_pc holds its last value; out_instr reads NOP_INSTR.
- Stall: with out_ready = 0, out_pc and out_instr stay bit-stable while out_valid = 1.
- Throughput: 1 pair/cycle sustained when out_ready = 1. Ordering is strict FIFO, and no pair is lost or duplicated across stall or unstall.
- Reset mid-operation: all entries are dropped immediately (async). No partial state survives.
- Widths: pass-through only; no arithmetic.

Decomposition:
- Package riscv_pipe_pkg:
  - state enum {EMPTY, BUSY, FULL}
  - NOP_INSTR default constant
  - typedef of the if_id payload struct {pc, instr}
- Sub-module pipe_skid_entry: a single payload register with load enable and valid bit. The block instantiates it twice (main and skid), or once when SKID_EN = 0.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, out_instr = 32'h13, out_pc = 0; in_ready = 1 on the first edge after release.
- Streaming: out_ready = 1, feed PC 0x00, 0x04, 0x08 with instructions 0x00500093, 0x00100113, 0x002081B3 -> the same pairs appear in order, 1 cycle later, with no bubbles.
- Stall (SKID_EN = 1):
  - Deassert out_ready for 3 cycles while streaming PC 0x10, 0x14, 0x18.
  - Expect out_pc held at 0x10, and in_ready = 0 from the cycle after 0x14 is accepted; 0x18 is not accepted during the stall.
  - On release, expect 0x14 then 0x18 in order, none lost or duplicated.
- Flush: flush = 1 in the FULL state with in_valid = 1 (PC 0x20) -> next cycle out_valid = 0, out_instr = 0x13, in_ready = 1, and PC 0x20 never appears at the output.
- Async reset mid-stream: assert rst = 0 between clock edges while in FULL -> out_valid = 0 immediately without a clock edge; after release, the first accepted pair (PC 0x40) emerges alone.
- SKID_EN = 0 variant: same stream as the stall test -> in_ready follows out_ready combinationally in the same cycle; order is preserved.
